four_12_12_st0_sched: RTL and testbench

Pass scheduler for the stage-0 controller of the four_12_12 network. It owns the single stage-0 datapath (tap memory, data and error FIFOs) and decides when a forward (data) pass or an error/tap-update pass runs. It issues start pulses, tracks how many forward passes still need their error pass, and drives the mode/first flags the stage control consumes. A watchdog catches a datapath that never reports completion.

---
 rtl/four_12_12_st0_sched_if.sv | 31 +++
 rtl/four_12_12_st0_sched.sv | 122 ++++++++++++
 tb/tb_four_12_12_st0_sched.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/four_12_12_st0_sched_if.sv
// Stage-0 scheduler handshake bundle: pass requests, done pulses,
// start pulses and scheduler status flags.
interface four_12_12_st0_sched_if;
  logic       flush;
  logic       fwd_req;
  logic       err_req;
  logic       fwd_done;
  logic       err_done;
  logic       upd_enable;
  logic       fwd_start;
  logic       err_start;
  logic       error_mode;
  logic       first;
  logic       busy;
  logic [2:0] outstanding;
  logic       fault;

  modport master (
    output flush, fwd_req, err_req,
    output fwd_done, err_done, upd_enable,
    input  fwd_start, err_start, error_mode,
    input  first, busy, outstanding, fault
  );

  modport slave (
    input  flush, fwd_req, err_req,
    input  fwd_done, err_done, upd_enable,
    output fwd_start, err_start, error_mode,
    output first, busy, outstanding, fault
  );
endinterface

// File: rtl/four_12_12_st0_sched.sv
// Stage-0 pass scheduler: arbitrates forward vs error/update passes
// on the shared datapath, tracks outstanding passes, watchdog fault.
module four_12_12_st0_sched #(
  parameter int BATCH   = 4,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic reset,
  four_12_12_st0_sched_if.slave bus
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] TO = W'(TIMEOUT);
  localparam logic [2:0] BMAX = 3'(BATCH);
  localparam logic [2:0] BLAST = 3'(BATCH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FWD_START,
    FWD_RUN,
    ERR_START,
    ERR_RUN,
    FAULT
  } state_t;

  state_t state, state_n;
  logic [2:0] outst, outst_n;
  logic [2:0] idx, idx_n;
  logic [W-1:0] wd, wd_n, wd_inc;
  logic fault, fault_n;
  logic fwd_ok, err_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      outst <= '0;
      idx   <= '0;
      wd    <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      outst <= outst_n;
      idx   <= idx_n;
      wd    <= wd_n;
      fault <= fault_n;
    end
  end

  assign fwd_ok = bus.fwd_req && (outst < BMAX);
  assign err_ok = bus.err_req && bus.upd_enable
               && (outst != 3'd0);
  // saturating so a stuck FAULT never wraps the count
  assign wd_inc = (wd == TO) ? wd : wd + 1'b1;

  always_comb begin
    state_n = state;
    outst_n = outst;
    idx_n   = idx;
    wd_n    = wd;
    fault_n = fault;
    if (bus.flush) begin
      state_n = IDLE;
      outst_n = '0;
      idx_n   = '0;
      wd_n    = '0;
      fault_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (err_ok)      state_n = ERR_START;
          else if (fwd_ok) state_n = FWD_START;
        end
        FWD_START: begin
          wd_n    = '0;
          state_n = FWD_RUN;
        end
        ERR_START: begin
          wd_n    = '0;
          state_n = ERR_RUN;
        end
        FWD_RUN: begin
          if (bus.fwd_done) begin
            state_n = IDLE;
            outst_n = outst + 3'd1;
            idx_n   = (idx == BLAST) ? 3'd0 : idx + 3'd1;
          end else begin
            wd_n = wd_inc;
            if (wd_inc == TO) begin
              state_n = FAULT;
              fault_n = 1'b1;
            end
          end
        end
        ERR_RUN: begin
          if (bus.err_done) begin
            state_n = IDLE;
            outst_n = outst - 3'd1;
          end else begin
            wd_n = wd_inc;
            if (wd_inc == TO) begin
              state_n = FAULT;
              fault_n = 1'b1;
            end
          end
        end
        FAULT: state_n = FAULT;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.fwd_start  = (state == FWD_START);
  assign bus.err_start  = (state == ERR_START);
  assign bus.error_mode = (state == ERR_START)
                       || (state == ERR_RUN);
  assign bus.first = ((state == FWD_START)
                   || (state == FWD_RUN)) && (idx == 3'd0);
  assign bus.busy        = (state != IDLE);
  assign bus.outstanding = outst;
  assign bus.fault       = fault;

endmodule

// File: tb/tb_four_12_12_st0_sched.sv
// Directed bench for four_12_12_st0_sched (BATCH=4, TIMEOUT=16).
// Inputs driven and outputs sampled on the falling edge.
module tb_four_12_12_st0_sched;

  logic clk;
  logic reset;
  int checks;
  int failures;

  four_12_12_st0_sched_if bus ();

  four_12_12_st0_sched #(
    .BATCH(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.flush = 0;
    bus.fwd_req = 0;
    bus.err_req = 0;
    bus.fwd_done = 0;
    bus.err_done = 0;
    bus.upd_enable = 1;
  endtask

  task automatic do_flush();
    bus.flush = 1;
    tick();
    bus.flush = 0;
  endtask

  task automatic do_fwd();
    bus.fwd_req = 1;
    tick();
    bus.fwd_req = 0;
    tick();
    bus.fwd_done = 1;
    tick();
    bus.fwd_done = 0;
  endtask

  task automatic test_reset();
    logic [8:0] o;
    reset = 0;
    idle_inputs();
    repeat (3) tick();
    o = {bus.fwd_start, bus.err_start, bus.error_mode,
         bus.first, bus.busy, bus.outstanding, bus.fault};
    checks++;
    if (o !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", o);
    end
    reset = 1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int n = 0;
    int cd = 0;
    bus.fwd_req = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      bus.fwd_done = 0;
      if (bus.fwd_start) begin
        checks++;
        if (bus.first !== (n == 0)) begin
          failures++;
          $display("FAIL basic_first pass=%0d got=%b want=%b",
                   n, bus.first, (n == 0));
        end
        n++;
        cd = 5;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) bus.fwd_done = 1;
      end
    end
    bus.fwd_req = 0;
    tick();
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL basic_count got=%0d want=4", n);
    end
    checks++;
    if (bus.outstanding !== 3'd4) begin
      failures++;
      $display("FAIL basic_outst got=%0d want=4", bus.outstanding);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_drain_priority();
    do_flush();
    checks++;
    if (bus.outstanding !== 3'd0) begin
      failures++;
      $display("FAIL flush_outst got=%0d want=0", bus.outstanding);
    end
    do_fwd();
    do_fwd();
    checks++;
    if (bus.outstanding !== 3'd2) begin
      failures++;
      $display("FAIL drain_setup got=%0d want=2", bus.outstanding);
    end
    bus.fwd_req = 1;
    bus.err_req = 1;
    tick();
    bus.fwd_req = 0;
    bus.err_req = 0;
    checks++;
    if ({bus.err_start, bus.fwd_start, bus.error_mode} !== 3'b101) begin
      failures++;
      $display("FAIL drain_grant got=%b want=101",
               {bus.err_start, bus.fwd_start, bus.error_mode});
    end
    tick();
    checks++;
    if ({bus.err_start, bus.error_mode, bus.outstanding} !== 5'b01010) begin
      failures++;
      $display("FAIL drain_run got=%b want=01010",
               {bus.err_start, bus.error_mode, bus.outstanding});
    end
    bus.err_done = 1;
    tick();
    bus.err_done = 0;
    checks++;
    if ({bus.error_mode, bus.outstanding} !== 4'b0001) begin
      failures++;
      $display("FAIL drain_done got=%b want=0001",
               {bus.error_mode, bus.outstanding});
    end
  endtask

  task automatic test_update_gate();
    int bad = 0;
    do_fwd();
    do_fwd();
    do_fwd();
    checks++;
    if (bus.outstanding !== 3'd4) begin
      failures++;
      $display("FAIL gate_setup got=%0d want=4", bus.outstanding);
    end
    bus.upd_enable = 0;
    bus.err_req = 1;
    bus.fwd_req = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.fwd_start || bus.err_start || bus.busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL gate_idle active_cycles=%0d want=0", bad);
    end
    bus.upd_enable = 1;
    tick();
    bus.err_req = 0;
    bus.fwd_req = 0;
    checks++;
    if (bus.err_start !== 1'b1) begin
      failures++;
      $display("FAIL gate_release got=%b want=1", bus.err_start);
    end
    tick();
    bus.err_done = 1;
    tick();
    bus.err_done = 0;
    checks++;
    if (bus.outstanding !== 3'd3) begin
      failures++;
      $display("FAIL gate_done got=%0d want=3", bus.outstanding);
    end
  endtask

  task automatic test_stray_done();
    bus.err_done = 1;
    tick();
    bus.err_done = 0;
    checks++;
    if ({bus.busy, bus.outstanding} !== 4'b0011) begin
      failures++;
      $display("FAIL stray_idle got=%b want=0011",
               {bus.busy, bus.outstanding});
    end
    bus.err_req = 1;
    tick();
    bus.err_req = 0;
    bus.fwd_done = 1;
    tick();
    tick();
    checks++;
    if ({bus.error_mode, bus.busy, bus.outstanding} !== 5'b11011) begin
      failures++;
      $display("FAIL stray_errrun got=%b want=11011",
               {bus.error_mode, bus.busy, bus.outstanding});
    end
    bus.fwd_done = 0;
    bus.err_done = 1;
    tick();
    bus.err_done = 0;
    checks++;
    if ({bus.busy, bus.outstanding} !== 4'b0010) begin
      failures++;
      $display("FAIL stray_end got=%b want=0010",
               {bus.busy, bus.outstanding});
    end
  endtask

  task automatic test_watchdog();
    int starts = 0;
    bus.fwd_req = 1;
    tick();
    bus.fwd_req = 0;
    checks++;
    if ({bus.fwd_start, bus.first} !== 2'b10) begin
      failures++;
      $display("FAIL wd_start got=%b want=10",
               {bus.fwd_start, bus.first});
    end
    repeat (16) tick();
    checks++;
    if ({bus.busy, bus.fault} !== 2'b10) begin
      failures++;
      $display("FAIL wd_early got=%b want=10", {bus.busy, bus.fault});
    end
    tick();
    checks++;
    if ({bus.busy, bus.fault} !== 2'b11) begin
      failures++;
      $display("FAIL wd_fault got=%b want=11", {bus.busy, bus.fault});
    end
    bus.fwd_req = 1;
    bus.err_req = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.fwd_start || bus.err_start || !bus.fault) starts++;
    end
    checks++;
    if (starts != 0) begin
      failures++;
      $display("FAIL wd_hold bad_cycles=%0d want=0", starts);
    end
    bus.flush = 1;
    bus.fwd_done = 1;
    tick();
    bus.flush = 0;
    bus.fwd_done = 0;
    bus.fwd_req = 0;
    bus.err_req = 0;
    checks++;
    if ({bus.fault, bus.busy, bus.outstanding} !== 5'b0) begin
      failures++;
      $display("FAIL wd_flush got=%b want=00000",
               {bus.fault, bus.busy, bus.outstanding});
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] o;
    do_fwd();
    bus.err_req = 1;
    tick();
    bus.err_req = 0;
    tick();
    checks++;
    if (bus.error_mode !== 1'b1) begin
      failures++;
      $display("FAIL ar_setup got=%b want=1", bus.error_mode);
    end
    #2 reset = 0;
    #1;
    o = {bus.fwd_start, bus.err_start, bus.error_mode,
         bus.first, bus.busy, bus.outstanding, bus.fault};
    checks++;
    if (o !== 9'd0) begin
      failures++;
      $display("FAIL ar_outputs got=%b want=0", o);
    end
    repeat (2) tick();
    reset = 1;
    bus.fwd_req = 1;
    tick();
    bus.fwd_req = 0;
    checks++;
    if ({bus.fwd_start, bus.first} !== 2'b11) begin
      failures++;
      $display("FAIL ar_first got=%b want=11",
               {bus.fwd_start, bus.first});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_drain_priority();
    test_update_gate();
    test_stray_done();
    test_watchdog();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
